// File: rtl/mips_code_loader.sv
// Boot loader: byte stream -> big-endian words -> imem, core held in reset until verified.
// Ports: clk, rst (sync low), start, in_valid/in_data/in_ready, imem_we/addr/wdata, core_rst, done, err.
module mips_code_loader #(
  parameter int CODE_DIR_WIDTH = 4,
  parameter int CODE_DEPTH     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_valid,
  input  logic [7:0]                in_data,
  output logic                      in_ready,
  output logic                      imem_we,
  output logic [CODE_DIR_WIDTH-1:0] imem_addr,
  output logic [31:0]               imem_wdata,
  output logic                      core_rst,
  output logic                      done,
  output logic                      err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_RUN,
    S_ERROR
  } state_e;

  state_e                    state_q;
  logic [CODE_DIR_WIDTH:0]   cnt_q;
  logic [CODE_DIR_WIDTH-1:0] widx_q;
  logic [1:0]                bidx_q;
  logic [31:0]               word_q;
  logic [7:0]                acc_q;

  logic                      in_ready_q;
  logic                      imem_we_q;
  logic [CODE_DIR_WIDTH-1:0] imem_addr_q;
  logic [31:0]               imem_wdata_q;
  logic                      core_rst_q;
  logic                      done_q;
  logic                      err_q;

  logic                      fire;
  logic [31:0]               word_d;
  logic [7:0]                acc_d;
  logic [CODE_DIR_WIDTH:0]   widx_d;
  logic                      cnt_ok;

  assign fire   = in_valid && in_ready_q;
  assign word_d = {word_q[23:0], in_data};
  assign acc_d  = acc_q ^ in_data;
  assign widx_d = {1'b0, widx_q} + (CODE_DIR_WIDTH+1)'(1);
  // Count is judged on the full byte so N > CODE_DEPTH cannot alias.
  assign cnt_ok = (in_data != 8'd0) && (32'(in_data) <= CODE_DEPTH);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      widx_q       <= '0;
      bidx_q       <= '0;
      word_q       <= '0;
      acc_q        <= '0;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_rst_q   <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_COUNT;
            in_ready_q <= 1'b1;
          end
        end
        S_COUNT: begin
          if (fire) begin
            if (cnt_ok) begin
              state_q <= S_DATA;
              cnt_q   <= (CODE_DIR_WIDTH+1)'(in_data);
              widx_q  <= '0;
              bidx_q  <= '0;
              acc_q   <= '0;
            end else begin
              state_q    <= S_ERROR;
              in_ready_q <= 1'b0;
              err_q      <= 1'b1;
            end
          end
        end
        S_DATA: begin
          if (fire) begin
            word_q <= word_d;
            acc_q  <= acc_d;
            bidx_q <= bidx_q + 2'd1;
            if (bidx_q == 2'd3) begin
              state_q      <= S_WRITE;
              in_ready_q   <= 1'b0;
              imem_we_q    <= 1'b1;
              imem_addr_q  <= widx_q;
              imem_wdata_q <= word_d;
            end
          end
        end
        S_WRITE: begin
          in_ready_q <= 1'b1;
          // Index stops at N-1 on the last word.
          if (widx_d < cnt_q) begin
            state_q <= S_DATA;
            widx_q  <= widx_d[CODE_DIR_WIDTH-1:0];
          end else begin
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (fire) begin
            in_ready_q <= 1'b0;
            if (in_data == acc_q) begin
              state_q    <= S_RUN;
              core_rst_q <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              state_q <= S_ERROR;
              err_q   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (start) begin
            state_q    <= S_COUNT;
            in_ready_q <= 1'b1;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        S_ERROR: begin
          if (start) begin
            state_q    <= S_COUNT;
            in_ready_q <= 1'b1;
            err_q      <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_rst   = core_rst_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: doc/mips_code_loader.md
# mips_code_loader

Boot-time program loader sitting directly upstream of the pipelined MIPS core.
- Accepts a byte stream over a valid/ready handshake and assembles 32-bit big-endian instruction words.
- Writes each word into the core's instruction memory through a one-cycle write port.
- Holds the core in reset until a complete, checksum-verified image has been written, then releases it.

## Interface
Parameters:
- CODE_DIR_WIDTH, 4, instruction-memory word-address width
- CODE_DEPTH, 16, instruction-memory depth in words; maximum loadable word count

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset; synchronous, active-low
- start  input  1  load request; sampled in IDLE, RUN and ERROR only
- in_valid  input  1  in_data holds a valid byte
- in_data  input  8  stream byte
- in_ready  output  1  loader can accept a byte this cycle
- imem_we  output  1  instruction-memory write strobe, one cycle per word
- imem_addr  output  CODE_DIR_WIDTH  word address for the write
- imem_wdata  output  32  word to write
- core_rst  output  1  active-high reset to the core; 1 = core held in reset
- done  output  1  image loaded and verified; core running
- err  output  1  load failed (bad count or checksum)

## Operation
- A byte is transferred on a rising edge when in_valid && in_ready. in_data is ignored otherwise.
- Frame format:
  - Count byte N, 1..CODE_DEPTH.
  - N×4 data bytes, most-significant byte of each word first.
  - One checksum byte equal to the XOR of all data bytes. The count byte is excluded from the checksum.
- States:
  - IDLE: core_rst=1, in_ready=0. start → COUNT.
  - COUNT: in_ready=1. Accepted byte with 1 ≤ N ≤ CODE_DEPTH → DATA, with word index 0, byte index 0 and checksum accumulator 0. N=0 or N>CODE_DEPTH → ERROR.
  - DATA: in_ready=1. Each accepted byte is shifted into the word register and XORed into the accumulator. The 4th byte of a word → WRITE.
  - WRITE: exactly one cycle. in_ready=0, imem_we=1, imem_addr=word index, imem_wdata=assembled word. Next state is DATA if word index+1 < N, otherwise CHECK. Word index increments.
  - CHECK: in_ready=1. Accepted byte equal to the accumulator → RUN, otherwise → ERROR.
  - RUN: core_rst=0, done=1. start → COUNT, with core_rst=1 and done=0 from the next cycle.
  - ERROR: core_rst=1, err=1. start → COUNT, clearing err.
- start is ignored in COUNT, DATA, WRITE and CHECK.
- Memory words at addresses ≥ N are not written and keep their previous contents.
- Word index never exceeds N-1. No address wrap is possible, because N > CODE_DEPTH is rejected.

## Timing
- Reset (rst=0 at an edge) values: state IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, done=0, err=0, all counters and the accumulator 0.
- Reset is honoured in every state, including mid-frame. A partial image is abandoned and the core stays in reset.
- All outputs are registered and change only on clock edges.
- Write latency: 4th data byte accepted at edge t → imem_we=1 during the cycle following t → write committed at edge t+1 → in_ready=1 again from edge t+1.
- Release latency: matching checksum byte accepted at edge k → core_rst=0 and done=1 from edge k.
- Error latency: bad count or checksum accepted at edge k → err=1 from edge k. core_rst remains 1.
- Back-pressure: in_valid may drop for any number of cycles at any point in the frame. State, counters and the accumulator hold.
- Minimum frame duration: 1 + 5N + 1 accepted-byte cycles. The +N term counts the WRITE cycles.

## Test plan
- Single word: reset, start, bytes 01 20 01 00 05 24 → one imem_we pulse with addr 0, wdata 0x20010005. Then core_rst=0, done=1, err=0.
- Bad checksum: same frame with final byte 25 → imem_we pulse at addr 0, then err=1, core_rst=1, done=0. A subsequent start clears err and accepts a good frame.
- Count bounds: count byte 00 → err=1. Count byte 11 (hex, = 17) → err=1. Count byte 10 (= 16) with 64 data bytes and correct XOR → 16 writes at addresses 0..15 in order, done=1.
- Back-pressure: in_valid toggled 1/0 every other cycle during a 2-word frame → same writes and values as the continuous case. in_ready=0 in every WRITE cycle, with no byte lost.
- Reset mid-load: rst=0 after 6 data bytes of a 3-word frame → next cycle all outputs at reset values. A fresh start/frame loads correctly from addr 0.
- Reload from RUN: start while done=1 → core_rst=1 and done=0 next cycle. A new 1-word frame overwrites addr 0 and releases the core again.
